latch_write_sched: RTL
======================

Name: latch_write_sched

Overview:
- Write scheduler for a bank of gated D-latch registers (d_latch_g style: level-sensitive En, transparent while high).
- Shares one latch data bus among N_REQ requesters and sequences each write as setup → enable pulse → hold, so D is never changing while any En is high.
- Sits between CPU-side write sources (e.g. regfile write port, debug port) and the latch bank.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each latch register
- ADDR_W, 2, register address width; bank has 2**ADDR_W registers
- EN_CYCLES, 1, clock cycles En is held high per write (>=1; 0 is illegal, flagged at elaboration)

Ports:
- CLK  in  1  system clock, rising-edge
- RST_N  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester write request, level
- req_addr  in  N_REQ*ADDR_W  packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, high from capture until the end of HOLD
- ack  out  N_REQ  one-hot, one-cycle write-complete pulse
- latch_d  out  WIDTH  shared D bus to all latches
- latch_en  out  2**ADDR_W  one-hot latch enables
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; gnt=0, ack=0, latch_en=0, latch_d=0, busy=0; arbiter pointer=0. Reset mid-write drops latch_en immediately; the latch keeps whatever it held (undefined if reset fell during ENABLE). No ack is issued for the aborted write.
- States: IDLE, SETUP, ENABLE, HOLD (enum in package).
- IDLE: on the rising edge with |req=1, arbitrate, register the winner's addr/data, set gnt[w], and go to SETUP. Otherwise stay.
- SETUP (1 cycle): latch_d=captured data, latch_en=0, then go to ENABLE.
- ENABLE (EN_CYCLES cycles, down-counter): latch_en[addr]=1, latch_d stable, then go to HOLD.
- HOLD (1 cycle): latch_en=0, latch_d still stable, ack[w]=1, then go to IDLE. gnt clears on exit.
- Latency: req sampled at edge t → ack high during cycle t+EN_CYCLES+2. Minimum write spacing is EN_CYCLES+3 cycles (IDLE always lasts ≥1 cycle).
- Data/addr are captured at grant. Later changes on req_data/req_addr do not affect the write in flight.
- Requester protocol: hold req until ack is seen, then deassert it on the edge that ends HOLD. A req still high in the following IDLE is a new write.
- Dropping req before ack: the write still completes and ack still pulses.
- Simultaneous requests: exactly one grant. Default is fixed priority, lowest index wins.
- latch_d holds its last value in IDLE; it is not cleared.
- Invariant: latch_d changes only on the edge entering SETUP; at most one latch_en bit is ever high.
- All outputs are registered; no combinational path from req to any output.

Optional Feature:
- Macro: LATCH_SCHED_RR_EN.
- Defined: round-robin arbitration. The pointer moves to (winner+1) mod N_REQ on each grant; search starts at the pointer.
- Undefined: fixed priority, lowest index wins; pointer logic is not built.

Decomposition:
- Package latch_sched_pkg: state enum (IDLE, SETUP, ENABLE, HOLD), state width constant, default WIDTH/ADDR_W constants.
- One sub-module, sched_arbiter: N_REQ-wide request vector in, one-hot grant out, pointer update strobe. Contains the LATCH_SCHED_RR_EN selection.
- The FSM, capture registers, EN_CYCLES counter and one-hot address decode stay in latch_write_sched.

Test Plan:
- Single write: req[1]=1, addr=2, data=0xA5 → SETUP with latch_d=0xA5 / en=0, then latch_en=4'b0100 for 1 cycle, then ack[1] pulse; D-latch model at addr 2 reads 0xA5.
- Contention, macro undefined: req=4'b1010 held → writes in order requester 1, 1, 1… (requester 3 starves while requester 1 re-requests). Macro defined: order 1, 3, 1, 3.
- Data change mid-write: req_data changes to 0x3C during ENABLE → latch stores the captured 0x5A; latch_d never toggles while any latch_en is high (assertion).
- EN_CYCLES=3: latch_en high exactly 3 cycles; ack at t+5; busy high for 5 cycles.
- Reset mid-ENABLE: RST_N low between clock edges → latch_en=0 and gnt=0 within the same timestep; no ack; after release, IDLE and the next req is serviced normally.
- Early req drop: req[0] deasserted during SETUP → write completes and ack[0] still pulses.

Source files
------------

// File: rtl/latch_sched_pkg.sv
// Shared types and defaults for the latch write scheduler.
// Optional round-robin arbitration is enabled by defining LATCH_SCHED_RR_EN.
package latch_sched_pkg;
  localparam int STATE_W    = 2;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ENABLE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;
endpackage

// File: rtl/sched_arbiter.sv
// One-hot requester arbiter. Fixed priority (lowest index) by default;
// defining LATCH_SCHED_RR_EN builds a round-robin pointer advanced by upd.
module sched_arbiter
  import latch_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  output logic [N_REQ-1:0] gnt
);
`ifdef LATCH_SCHED_RR_EN
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr, win;
  logic             found;
  int               idx;

  // Search starts at the pointer and wraps around the request vector.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (upd) ptr <= (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, upd};
  assign gnt       = req & (-req);
`endif
endmodule

// File: rtl/latch_write_sched.sv
// Sequences shared-bus writes into a gated D-latch bank: setup, enable pulse, hold.
// Arbitration mode follows LATCH_SCHED_RR_EN (see sched_arbiter).
module latch_write_sched
  import latch_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int EN_CYCLES = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [WIDTH-1:0]          latch_d,
  output logic [(1<<ADDR_W)-1:0]    latch_en,
  output logic                      busy
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  if (EN_CYCLES < 1) begin : g_bad_en
    $error("EN_CYCLES must be >= 1");
  end

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q, sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic [N_REQ-1:0]   arb_gnt;
  logic [NREG-1:0]    addr_dec;
  logic               upd;

  assign upd      = (state == S_IDLE) && (|req);
  assign addr_dec = NREG'(1) << addr_q;
  assign busy     = (state != S_IDLE);

  sched_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   (req),
    .upd   (upd),
    .gnt   (arb_gnt)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // latch_d is only loaded on the capture edge, so it is stable for SETUP..HOLD.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      gnt      <= '0;
      ack      <= '0;
      latch_d  <= '0;
      latch_en <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          gnt     <= arb_gnt;
          addr_q  <= sel_addr;
          latch_d <= sel_data;
          state   <= S_SETUP;
        end
        S_SETUP: begin
          latch_en <= addr_dec;
          cnt      <= CNT_W'(EN_CYCLES - 1);
          state    <= S_ENABLE;
        end
        S_ENABLE: begin
          if (cnt == '0) begin
            latch_en <= '0;
            ack      <= gnt;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          ack   <= '0;
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
